// File: rtl/bitpattern_generator.sv
// Serial thermometer-code generator: turns a requested ones-count into a
// right-justified run of 1s, shifting in one bit per clock under a start/done handshake.
module bitpattern_generator #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] pattern,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUILD = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pattern_q, pattern_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               over_width;

  // Requests above WIDTH saturate and raise err.
  assign over_width = (count > WIDTH_C);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_d = '0;
          cnt_d     = over_width ? WIDTH_C : count;
          err_d     = over_width;
          state_d   = S_BUILD;
        end
      end
      S_BUILD: begin
        if (cnt_q != '0) begin
          pattern_d = {pattern_q[WIDTH-2:0], 1'b1};
          cnt_d     = cnt_q - 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Start must drop before another request can be taken.
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pattern_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign pattern   = pattern_q;
  assign dbg_state = state_q;

endmodule
